// File: rtl/xor_nn_pkg.sv
// Shared xor_nn constants and types: loader states, layer select, layer geometry, frame sync byte.
package xor_nn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAYER,
      DATA,
      CSUM,
      COMMIT
   } state_e;

   typedef enum logic {
      LAYER_W1 = 1'b0,
      LAYER_W2 = 1'b1
   } layer_e;

   localparam logic [7:0] XOR_NN_SYNC_BYTE = 8'hA5;

   localparam int XOR_NN_L0_ROWS = 3;
   localparam int XOR_NN_L0_COLS = 2;
   localparam int XOR_NN_L1_ROWS = 3;
   localparam int XOR_NN_L1_COLS = 1;

   localparam int XOR_NN_STAGE_DEPTH = 8;
   localparam int XOR_NN_STAGE_PTR_W = 3;

endpackage

// File: rtl/xor_nn_weight_stage.sv
// Staging register file holding one frame's weights until its checksum has been verified.
module xor_nn_weight_stage
   import xor_nn_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          wr_en,
   input  logic [XOR_NN_STAGE_PTR_W-1:0] wr_ptr,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic [XOR_NN_STAGE_PTR_W-1:0] rd_ptr,
   output logic [WIDTH-1:0]              rd_data
);

   logic [WIDTH-1:0] mem_q [0:XOR_NN_STAGE_DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/xor_nn_weight_loader.sv
// Parses SYNC/LAYER/weight byte frames into row-major xor_nn weight writes.
// Define XOR_NN_LOADER_CHECKSUM_EN to stage a frame and commit it only when its trailing checksum matches.
module xor_nn_weight_loader
   import xor_nn_pkg::*;
#(
   parameter int         BITS_PER_WORD       = 8,
   parameter int         L0_ROWS             = XOR_NN_L0_ROWS,
   parameter int         L0_COLS             = XOR_NN_L0_COLS,
   parameter int         L1_ROWS             = XOR_NN_L1_ROWS,
   parameter int         L1_COLS             = XOR_NN_L1_COLS,
   parameter int         CLOG2_MAX_WEIGHTS_N = 2,
   parameter int         CLOG2_MAX_WEIGHTS_M = 2,
   parameter logic [7:0] SYNC_BYTE           = XOR_NN_SYNC_BYTE
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [7:0]                     s_data,
   output logic                           weights_en,
   output logic                           weights_layer_address,
   output logic [CLOG2_MAX_WEIGHTS_N-1:0] weights_n_address,
   output logic [CLOG2_MAX_WEIGHTS_M-1:0] weights_m_address,
   output logic [BITS_PER_WORD-1:0]       weights_data,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);

   localparam int NW = CLOG2_MAX_WEIGHTS_N;
   localparam int MW = CLOG2_MAX_WEIGHTS_M;

   state_e                   state_q, state_d;
   layer_e                   layer_q, layer_d;
   logic [NW-1:0]            n_q, n_d, n_adv, rows_last;
   logic [MW-1:0]            m_q, m_d, m_adv, cols_last;
   logic                     wen_q, wen_d;
   logic                     laddr_q, laddr_d;
   logic [NW-1:0]            naddr_q, naddr_d;
   logic [MW-1:0]            maddr_q, maddr_d;
   logic [BITS_PER_WORD-1:0] data_q, data_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
   logic                     accept, last_weight, m_wrap;

   assign s_ready = !reset && (state_q != COMMIT);
   assign accept  = s_valid && s_ready;

   assign rows_last   = (layer_q == LAYER_W2) ? NW'(L1_ROWS - 1) : NW'(L0_ROWS - 1);
   assign cols_last   = (layer_q == LAYER_W2) ? MW'(L1_COLS - 1) : MW'(L0_COLS - 1);
   assign m_wrap      = (m_q == cols_last);
   assign last_weight = (n_q == rows_last) && m_wrap;
   assign m_adv       = m_wrap ? '0 : m_q + 1'b1;
   assign n_adv       = m_wrap ? n_q + 1'b1 : n_q;

`ifdef XOR_NN_LOADER_CHECKSUM_EN
   logic [7:0]                    sum_q, sum_d;
   logic [XOR_NN_STAGE_PTR_W-1:0] ptr_q, ptr_d;
   logic                          stage_we, issue;
   logic [BITS_PER_WORD-1:0]      stage_rd;

   // One pointer serves both phases: filling during DATA, draining during COMMIT.
   xor_nn_weight_stage #(.WIDTH(BITS_PER_WORD)) u_stage (
      .clk     (clk),
      .wr_en   (stage_we),
      .wr_ptr  (ptr_q),
      .wr_data (s_data),
      .rd_ptr  (ptr_q),
      .rd_data (stage_rd)
   );
`endif

   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      n_d     = n_q;
      m_d     = m_q;
      wen_d   = 1'b0;
      laddr_d = laddr_q;
      naddr_d = naddr_q;
      maddr_d = maddr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
`ifdef XOR_NN_LOADER_CHECKSUM_EN
      sum_d    = sum_q;
      ptr_d    = ptr_q;
      stage_we = 1'b0;
      issue    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (accept && (s_data == SYNC_BYTE)) state_d = LAYER;
         end
         LAYER: begin
            if (accept) begin
               if (s_data <= 8'd1) begin
                  layer_d = layer_e'(s_data[0]);
                  n_d     = '0;
                  m_d     = '0;
                  state_d = DATA;
`ifdef XOR_NN_LOADER_CHECKSUM_EN
                  sum_d   = s_data;
                  ptr_d   = '0;
`endif
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (accept) begin
`ifdef XOR_NN_LOADER_CHECKSUM_EN
               stage_we = 1'b1;
               sum_d    = sum_q + s_data;
               ptr_d    = ptr_q + 1'b1;
               if (last_weight) begin
                  ptr_d   = '0;
                  n_d     = '0;
                  m_d     = '0;
                  state_d = CSUM;
               end else begin
                  n_d = n_adv;
                  m_d = m_adv;
               end
`else
               wen_d   = 1'b1;
               laddr_d = layer_q;
               naddr_d = n_q;
               maddr_d = m_q;
               data_d  = s_data;
               if (last_weight) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  n_d = n_adv;
                  m_d = m_adv;
               end
`endif
            end
         end
`ifdef XOR_NN_LOADER_CHECKSUM_EN
         CSUM: begin
            if (accept) begin
               if (8'(sum_q + s_data) == 8'd0) begin
                  issue   = 1'b1;
                  state_d = COMMIT;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         COMMIT: issue = 1'b1;
`else
         CSUM, COMMIT: state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
`ifdef XOR_NN_LOADER_CHECKSUM_EN
      // The first commit write leaves on the checksum edge so writes follow acceptance back-to-back.
      if (issue) begin
         wen_d   = 1'b1;
         laddr_d = layer_q;
         naddr_d = n_q;
         maddr_d = m_q;
         data_d  = stage_rd;
         ptr_d   = ptr_q + 1'b1;
         if (last_weight) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end else begin
            n_d = n_adv;
            m_d = m_adv;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         layer_q <= LAYER_W1;
         n_q     <= '0;
         m_q     <= '0;
         wen_q   <= 1'b0;
         laddr_q <= 1'b0;
         naddr_q <= '0;
         maddr_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef XOR_NN_LOADER_CHECKSUM_EN
         sum_q   <= '0;
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         n_q     <= n_d;
         m_q     <= m_d;
         wen_q   <= wen_d;
         laddr_q <= laddr_d;
         naddr_q <= naddr_d;
         maddr_q <= maddr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef XOR_NN_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign weights_en            = wen_q;
   assign weights_layer_address = laddr_q;
   assign weights_n_address     = naddr_q;
   assign weights_m_address     = maddr_q;
   assign weights_data          = data_q;
   assign busy                  = (state_q != IDLE);
   assign done                  = done_q;
   assign err                   = err_q;

endmodule

// File: tb/tb_xor_nn_weight_loader.sv
// Directed plus randomized frames for xor_nn_weight_loader, checked against a frame-level reference model.
module tb_xor_nn_weight_loader;

`ifdef XOR_NN_LOADER_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_ready, weights_en, weights_layer_address, busy, done, err;
   logic [1:0] weights_n_address, weights_m_address;
   logic [7:0] weights_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] got_w[$], exp_w[$];
   int          got_d[$], exp_d[$], got_e[$], exp_e[$];
   logic [7:0]  pre_q[$], wts_q[$], frame_q[$];
   int          acc_q[$];

   xor_nn_weight_loader dut (
      .clk                   (clk),
      .reset                 (reset),
      .s_valid               (s_valid),
      .s_ready               (s_ready),
      .s_data                (s_data),
      .weights_en            (weights_en),
      .weights_layer_address (weights_layer_address),
      .weights_n_address     (weights_n_address),
      .weights_m_address     (weights_m_address),
      .weights_data          (weights_data),
      .busy                  (busy),
      .done                  (done),
      .err                   (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (weights_en)
            got_w.push_back({cyc[15:0], 3'b000, weights_layer_address,
                             weights_n_address, weights_m_address, weights_data});
         if (done) got_d.push_back(cyc);
         if (err)  got_e.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input int c, input logic l, input int n, input int m,
                                        input logic [7:0] d);
      logic [31:0] cc, nn, mm;
      cc = c;
      nn = n;
      mm = m;
      return {cc[15:0], 3'b000, l, nn[1:0], mm[1:0], d};
   endfunction

   task automatic clear_events();
      got_w.delete(); got_d.delete(); got_e.delete();
      exp_w.delete(); exp_d.delete(); exp_e.delete();
   endtask

   task automatic compare_events(input string tag);
      chk({tag, "_nwrites"}, 32'(got_w.size()), 32'(exp_w.size()));
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
         chk({tag, "_write"}, got_w[i], exp_w[i]);
      chk({tag, "_ndone"}, 32'(got_d.size()), 32'(exp_d.size()));
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
         chk({tag, "_done_cyc"}, 32'(got_d[i]), 32'(exp_d[i]));
      chk({tag, "_nerr"}, 32'(got_e.size()), 32'(exp_e.size()));
      for (int i = 0; i < exp_e.size() && i < got_e.size(); i++)
         chk({tag, "_err_cyc"}, 32'(got_e[i]), 32'(exp_e[i]));
   endtask

   // Every byte must be accepted on the first edge it is offered; acc_q holds each byte's cycle stamp.
   task automatic send_frame();
      acc_q.delete();
      foreach (frame_q[i]) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = frame_q[i];
         chk("s_ready_on_offer", 32'(s_ready), 32'd1);
         @(posedge clk);
         #1;
         acc_q.push_back(cyc);
         s_valid = 1'b0;
      end
   endtask

   task automatic run_frame(input string tag, input logic [7:0] layer, input logic [7:0] delta);
      logic [7:0] sum;
      bit         ok_layer, ok_sum;
      int         li, cols, cnt, cs_acc;
      frame_q = pre_q;
      frame_q.push_back(8'hA5);
      frame_q.push_back(layer);
      ok_layer = (layer <= 8'd1);
      sum = layer;
      if (ok_layer) begin
         foreach (wts_q[i]) begin
            frame_q.push_back(wts_q[i]);
            sum = sum + wts_q[i];
         end
         if (CSUM_ON) frame_q.push_back(8'(8'd0 - sum + delta));
      end
      ok_sum = !CSUM_ON || (delta == 8'd0);
      clear_events();
      send_frame();
      li   = pre_q.size() + 1;
      cols = (layer == 8'd1) ? 1 : 2;
      cnt  = wts_q.size();
      if (!ok_layer) begin
         exp_e.push_back(acc_q[li]);
      end else if (!CSUM_ON) begin
         for (int k = 0; k < cnt; k++)
            exp_w.push_back(pack(acc_q[li + 1 + k], layer[0], k / cols, k % cols, wts_q[k]));
         exp_d.push_back(acc_q[li + cnt]);
      end else if (!ok_sum) begin
         exp_e.push_back(acc_q[li + cnt + 1]);
      end else begin
         cs_acc = acc_q[li + cnt + 1];
         for (int k = 0; k < cnt; k++)
            exp_w.push_back(pack(cs_acc + k, layer[0], k / cols, k % cols, wts_q[k]));
         exp_d.push_back(cs_acc + cnt - 1);
      end
      chk({tag, "_busy_after_last"}, 32'(busy), 32'(CSUM_ON && ok_layer && ok_sum));
      repeat (12) @(negedge clk);
      compare_events(tag);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   task automatic fill_random_weights(input logic [7:0] layer);
      int n;
      wts_q.delete();
      n = (layer == 8'd1) ? 3 : 6;
      for (int i = 0; i < n; i++)
         wts_q.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin : stim
      logic [7:0] lay, dl, jb;
      // Reset held for three cycles: every output low, s_ready low.
      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs", {14'b0, s_ready, weights_en, weights_layer_address, weights_n_address,
                               weights_m_address, weights_data, busy, done, err}, 32'd0);
      end
      #1 reset = 1'b0;
      @(negedge clk);
      chk("s_ready_after_reset", 32'(s_ready), 32'd1);

      pre_q.delete();
      wts_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      run_frame("l0_frame", 8'h00, 8'h00);

      pre_q = {8'h00, 8'h37};
      wts_q = {8'h02, 8'hFE, 8'h03};
      run_frame("l1_junk_frame", 8'h01, 8'h00);
      run_frame("l1_bad_csum", 8'h01, 8'h01);

      pre_q.delete();
      wts_q.delete();
      run_frame("bad_layer", 8'h02, 8'h00);
      fill_random_weights(8'h00);
      run_frame("after_bad_layer", 8'h00, 8'h00);

      // Reset in the middle of a frame.
      clear_events();
      frame_q = {8'hA5, 8'h00, 8'h01, 8'h02};
      send_frame();
      @(negedge clk);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      repeat (6) @(negedge clk);
      if (!CSUM_ON) begin
         exp_w.push_back(pack(acc_q[2], 1'b0, 0, 0, 8'h01));
         exp_w.push_back(pack(acc_q[3], 1'b0, 0, 1, 8'h02));
      end
      compare_events("mid_frame_reset");
      chk("mid_frame_reset_busy", 32'(busy), 32'd0);
      wts_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      run_frame("after_reset_frame", 8'h00, 8'h00);

      for (int f = 0; f < 25; f++) begin
         pre_q.delete();
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'hA5) jb = 8'h5A;
            pre_q.push_back(jb);
         end
         lay = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
         if (lay <= 8'd1) fill_random_weights(lay);
         else wts_q.delete();
         dl = (CSUM_ON && $urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         run_frame("random_frame", lay, dl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
